// File: rtl/mem_write_buffer_if.sv
// Store-request and memory-write signals between the datapath, the write buffer and memory.
// The buffer uses the slave view; the datapath/memory side uses the master view.
interface mem_write_buffer_if;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_size;
    logic        mem_wr_en;
    logic        mem_wr_ack;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;

    modport master (
        output st_valid, st_addr, st_data, st_size, mem_wr_ack,
        input  st_ready, mem_wr_en, mem_addr, mem_wdata, mem_be
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_size, mem_wr_ack,
        output st_ready, mem_wr_en, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/mem_write_buffer.sv
// Store write buffer: formats byte/half/word stores into word-aligned lane writes, queues them
// in a DEPTH-entry FIFO and drains them to memory over an en/ack handshake.
module mem_write_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    mem_write_buffer_if.slave        bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic                     misalign_err
);

    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic S_IDLE  = 1'b0;
    localparam logic S_WRITE = 1'b1;

    logic          state;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count_next;

    logic [31:0] fifo_addr [DEPTH];
    logic [31:0] fifo_data [DEPTH];
    logic [3:0]  fifo_be   [DEPTH];

    logic [1:0]  ofs;
    logic        legal;
    logic [3:0]  fmt_be;
    logic [31:0] fmt_data;
    logic        accept;
    logic        push;
    logic        pop;

    // Little-endian lane formatting; data is replicated so any enabled lane carries it.
    always_comb begin
        ofs      = bus.st_addr[1:0];
        legal    = 1'b0;
        fmt_be   = 4'b0000;
        fmt_data = bus.st_data;
        case (bus.st_size)
            2'b00: begin
                legal    = 1'b1;
                fmt_be   = 4'b0001 << ofs;
                fmt_data = {4{bus.st_data[7:0]}};
            end
            2'b01: begin
                legal    = ~ofs[0];
                fmt_be   = ofs[1] ? 4'b1100 : 4'b0011;
                fmt_data = {2{bus.st_data[15:0]}};
            end
            2'b10: begin
                legal    = (ofs == 2'b00);
                fmt_be   = 4'b1111;
            end
            default: legal = 1'b0;
        endcase
    end

    // Ready depends on the registered count only, never on mem_wr_ack.
    assign bus.st_ready = (count < (AW+1)'(DEPTH));
    assign busy         = (count != '0);

    assign accept = bus.st_valid && bus.st_ready;
    assign push   = accept && legal;
    assign pop    = (state == S_WRITE) && bus.mem_wr_ack;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + (AW+1)'(1);
            2'b01:   count_next = count - (AW+1)'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wptr] <= {bus.st_addr[31:2], 2'b00};
            fifo_data[wptr] <= fmt_data;
            fifo_be[wptr]   <= fmt_be;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            wptr          <= '0;
            rptr          <= '0;
            count         <= '0;
            misalign_err  <= 1'b0;
            bus.mem_wr_en <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_be    <= '0;
        end else begin
            count        <= count_next;
            misalign_err <= accept && !legal;
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            case (state)
                S_IDLE: begin
                    if (count != '0) begin
                        bus.mem_addr  <= fifo_addr[rptr];
                        bus.mem_wdata <= fifo_data[rptr];
                        bus.mem_be    <= fifo_be[rptr];
                        bus.mem_wr_en <= 1'b1;
                        state         <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    // Dropping en here guarantees an idle cycle between writes.
                    if (bus.mem_wr_ack) begin
                        bus.mem_wr_en <= 1'b0;
                        rptr          <= rptr + AW'(1);
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_write_buffer.sv
// Self-checking bench for mem_write_buffer: directed scenarios plus randomized stores,
// with a scoreboard monitor comparing every memory write against a reference model.
module tb_mem_write_buffer;

    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] count;
    logic       busy;
    logic       misalign_err;

    int tests = 0;
    int fails = 0;
    int ack_mode = 1;     // 0: ack always high, 1: ack held low, 2: random ack
    int mis_pending = 0;
    int model_count = 0;
    wr_t sb[$];

    mem_write_buffer_if bus ();

    mem_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .count        (count),
        .busy         (busy),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got timeout, expected completion", name);
    endtask

    function automatic bit is_legal(input logic [31:0] addr, input logic [1:0] size);
        int o;
        o = int'(addr % 4);
        return (size == 2'd0) || (size == 2'd1 && o % 2 == 0) || (size == 2'd2 && o == 0);
    endfunction

    function automatic wr_t model_wr(input logic [31:0] addr, input logic [31:0] data,
                                     input logic [1:0] size);
        wr_t r;
        int  o;
        o      = int'(addr % 4);
        r.addr = addr - 32'(o);
        case (size)
            2'd0: begin
                r.be   = 4'(1 << o);
                r.data = 32'(data % 256) * 32'h0101_0101;
            end
            2'd1: begin
                r.be   = 4'(3 << o);
                r.data = 32'(data % 65536) * 32'h0001_0001;
            end
            default: begin
                r.be   = 4'hf;
                r.data = data;
            end
        endcase
        return r;
    endfunction

    // Issue one store starting at posedge+1; valid stays high after acceptance so stores
    // can go back to back.
    task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
        bit done = 0;
        bus.st_valid = 1'b1;
        bus.st_addr  = addr;
        bus.st_data  = data;
        bus.st_size  = size;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (bus.st_ready) begin
                done = 1;
                if (is_legal(addr, size)) sb.push_back(model_wr(addr, data, size));
                else mis_pending++;
            end
            @(posedge clk);
            #1;
        end
        bus.st_valid = 1'b0;
        if (!done) timeout_fail("store_accept");
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) done = 1;
        end
        if (!done) timeout_fail("drain");
        @(posedge clk);
        #1;
    endtask

    // After a store into an empty buffer with ack high: en low one cycle, then one write.
    task automatic check_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        @(negedge clk);
        check("latency_en_low", 32'(bus.mem_wr_en), 32'd0);
        check("count_after_accept", 32'(count), 32'd1);
        @(negedge clk);
        check("latency_en_high", 32'(bus.mem_wr_en), 32'd1);
        check("dir_addr", bus.mem_addr, a);
        check("dir_be", 32'(bus.mem_be), 32'(be));
        check("dir_wdata", bus.mem_wdata, d);
        @(negedge clk);
        check("en_after_ack", 32'(bus.mem_wr_en), 32'd0);
        check("count_after_ack", 32'(count), 32'd0);
        check("busy_after_ack", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Memory-side acknowledge generator.
    initial begin
        bus.mem_wr_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ack_mode)
                0:       bus.mem_wr_ack = 1'b1;
                1:       bus.mem_wr_ack = 1'b0;
                default: bus.mem_wr_ack = ($urandom_range(0, 2) == 0);
            endcase
        end
    end

    // Scoreboard monitor: everything seen here describes the state before the next posedge.
    initial begin
        bit prev_done = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                model_count = 0;
                mis_pending = 0;
                sb.delete();
                prev_done = 0;
            end else begin
                check("count", 32'(count), 32'(model_count));
                check("st_ready", 32'(bus.st_ready), 32'(model_count < int'(DEPTH)));
                check("busy", 32'(busy), 32'(model_count != 0));
                if (misalign_err) begin
                    tests++;
                    if (mis_pending > 0) mis_pending--;
                    else begin
                        fails++;
                        $display("FAIL misalign_err: got 1, expected 0");
                    end
                end
                if (prev_done) check("gap_between_writes", 32'(bus.mem_wr_en), 32'd0);
                prev_done = 0;
                if (bus.mem_wr_en) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL spurious_write: got en=1, expected no write pending");
                    end else begin
                        check("wr_addr", bus.mem_addr, sb[0].addr);
                        check("wr_data", bus.mem_wdata, sb[0].data);
                        check("wr_be", 32'(bus.mem_be), 32'(sb[0].be));
                        if (bus.mem_wr_ack) begin
                            void'(sb.pop_front());
                            model_count--;
                            prev_done = 1;
                        end
                    end
                end
                if (bus.st_valid && bus.st_ready && is_legal(bus.st_addr, bus.st_size))
                    model_count++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got time limit, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.st_valid = 1'b0;
        bus.st_addr  = '0;
        bus.st_data  = '0;
        bus.st_size  = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_count", 32'(count), 32'd0);
        check("rst_en", 32'(bus.mem_wr_en), 32'd0);
        check("rst_ready", 32'(bus.st_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mis", 32'(misalign_err), 32'd0);
        check("rst_addr", bus.mem_addr, 32'd0);
        check("rst_wdata", bus.mem_wdata, 32'd0);
        check("rst_be", 32'(bus.mem_be), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycles(2);

        // Single word, byte and half stores with immediate ack.
        ack_mode = 0;
        store(32'h100, 32'hDEAD_BEEF, 2'd2);
        check_write(32'h100, 4'b1111, 32'hDEAD_BEEF);
        store(32'h203, 32'h0000_00A5, 2'd0);
        check_write(32'h200, 4'b1000, 32'hA5A5_A5A5);
        store(32'h202, 32'h0000_1234, 2'd1);
        check_write(32'h200, 4'b1100, 32'h1234_1234);

        // Illegal stores are dropped with a one-cycle error pulse.
        store(32'h101, 32'h1111_1111, 2'd2);
        @(negedge clk);
        check("mis_word", 32'(misalign_err), 32'd1);
        @(posedge clk);
        #1;
        store(32'h103, 32'h2222_2222, 2'd1);
        @(negedge clk);
        check("mis_half", 32'(misalign_err), 32'd1);
        @(posedge clk);
        #1;
        store(32'h100, 32'h3333_3333, 2'd3);
        @(negedge clk);
        check("mis_size", 32'(misalign_err), 32'd1);
        @(negedge clk);
        check("mis_pulse_end", 32'(misalign_err), 32'd0);
        check("mis_count", 32'(count), 32'd0);
        check("mis_no_en", 32'(bus.mem_wr_en), 32'd0);
        @(posedge clk);
        #1;

        // Fill with ack held low, then release.
        ack_mode = 1;
        fork
            for (int i = 0; i < 5; i++) store(32'h400 + 32'(i * 4), $urandom, 2'd2);
            begin
                idle_cycles(20);
                @(negedge clk);
                check("full_ready", 32'(bus.st_ready), 32'd0);
                check("full_count", 32'(count), 32'd4);
                @(posedge clk);
                #1;
                ack_mode = 0;
            end
        join
        wait_idle();

        // Randomized stores with random ack timing, crossing pointer wrap many times.
        ack_mode = 2;
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            logic [1:0]  s;
            a = $urandom;
            s = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) != 0) begin
                if (s == 2'd3) s = 2'd2;
                if (s == 2'd1) a[0] = 1'b0;
                if (s == 2'd2) a[1:0] = 2'b00;
            end
            store(a, $urandom, s);
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
        end
        wait_idle();
        idle_cycles(2);
        check("mis_all_seen", 32'(mis_pending), 32'd0);

        // Reset while a write is outstanding with entries queued.
        ack_mode = 1;
        for (int i = 0; i < 3; i++) store(32'h800 + 32'(i * 4), $urandom, 2'd2);
        begin
            bit seen = 0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (bus.mem_wr_en) seen = 1;
            end
            if (!seen) timeout_fail("wait_en_before_rst");
        end
        check("pre_rst_count", 32'(count), 32'd3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_en", 32'(bus.mem_wr_en), 32'd0);
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_ready", 32'(bus.st_ready), 32'd1);
        check("midrst_addr", bus.mem_addr, 32'd0);
        @(posedge clk);
        #1;
        ack_mode = 0;
        idle_cycles(6);
        @(negedge clk);
        check("late_ack_en", 32'(bus.mem_wr_en), 32'd0);
        check("late_ack_count", 32'(count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
